// File: rtl/block_idct_if.sv
// Handshake bundle for block_idct: row packet streams, 1-D IDCT core port
// and the destination coordinates stamped on outgoing rows.
interface block_idct_if #(
    parameter int X_SIZE     = 4,
    parameter int Y_SIZE     = 4,
    parameter int PCK_NUM    = 16,
    parameter int DATA_WIDTH = 256
);
    localparam int TOTAL_WIDTH = DATA_WIDTH + PCK_NUM + Y_SIZE + X_SIZE;

    logic [TOTAL_WIDTH-1:0] i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic [TOTAL_WIDTH-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic [X_SIZE-1:0]      dst_x;
    logic [Y_SIZE-1:0]      dst_y;
    logic [DATA_WIDTH-1:0]  c_data;
    logic                   c_valid;
    logic                   c_ready;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_valid;
    logic                   r_ready;

    modport slave (
        input  i_data, i_valid, i_ready, dst_x, dst_y,
        input  c_ready, r_data, r_valid,
        output o_ready, o_data, o_valid,
        output c_data, c_valid, r_ready
    );

    modport master (
        output i_data, i_valid, i_ready, dst_x, dst_y,
        output c_ready, r_data, r_valid,
        input  o_ready, o_data, o_valid,
        input  c_data, c_valid, r_ready
    );
endinterface

// File: rtl/block_idct.sv
// 8x8 block inverse DCT sequencer: buffers 8 row packets, drives 8 column
// then 8 row passes through an external 1-D IDCT core, re-stamps and emits rows.
module block_idct #(
    parameter int X_SIZE     = 4,
    parameter int Y_SIZE     = 4,
    parameter int PCK_NUM    = 16,
    parameter int DATA_WIDTH = 256
) (
    input logic         clk,
    input logic         rstn,
    block_idct_if.slave bus
);
    localparam int XY = X_SIZE + Y_SIZE;
    localparam int TW = DATA_WIDTH + PCK_NUM + XY;
    localparam int EW = 32;
    localparam int NE = 8;
    localparam int AW = $clog2(TW);

    typedef enum logic [2:0] {
        RECV,
        COL_ISSUE,
        COL_WAIT,
        ROW_ISSUE,
        ROW_WAIT,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [X_SIZE-1:0] dx_q, dx_d;
    logic [Y_SIZE-1:0] dy_q, dy_d;
    logic [TW-1:0]     mem_q [NE];
    logic [TW-1:0]     mem_d [NE];

    logic [DATA_WIDTH-1:0] col_v;
    logic [TW-1:0]         row_k;
    logic [AW-1:0]         col_msb;
    logic                  in_fire, c_fire, r_fire, o_fire;

    // Column k lives at the same element slot in every row.
    assign col_msb = AW'(TW - 1 - EW * int'(k_q));
    assign row_k   = mem_q[k_q];

    assign bus.o_ready = (state_q == RECV);
    assign bus.c_valid = (state_q == COL_ISSUE) || (state_q == ROW_ISSUE);
    assign bus.r_ready = (state_q == COL_WAIT) || (state_q == ROW_WAIT);
    assign bus.o_valid = (state_q == SEND);

    assign in_fire = bus.i_valid && bus.o_ready;
    assign c_fire  = bus.c_valid && bus.c_ready;
    assign r_fire  = bus.r_valid && bus.r_ready;
    assign o_fire  = bus.o_valid && bus.i_ready;

    always_comb begin
        col_v = '0;
        for (int j = 0; j < NE; j++) begin
            col_v[DATA_WIDTH-1-EW*j -: EW] = mem_q[j][col_msb -: EW];
        end
    end

    always_comb begin
        bus.c_data = '0;
        unique case (state_q)
            COL_ISSUE: bus.c_data = col_v;
            ROW_ISSUE: bus.c_data = row_k[TW-1 -: DATA_WIDTH];
            default:   bus.c_data = '0;
        endcase
    end

    assign bus.o_data = (state_q == SEND)
                      ? {row_k[TW-1 -: DATA_WIDTH+PCK_NUM], dy_q, dx_q}
                      : '0;

    always_comb begin
        mem_d = mem_q;
        if (in_fire) begin
            mem_d[bus.i_data[XY +: 3]] = bus.i_data;
        end
        if (r_fire && state_q == COL_WAIT) begin
            for (int j = 0; j < NE; j++) begin
                mem_d[j][col_msb -: EW] = bus.r_data[DATA_WIDTH-1-EW*j -: EW];
            end
        end
        if (r_fire && state_q == ROW_WAIT) begin
            mem_d[k_q][TW-1 -: DATA_WIDTH] = bus.r_data;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        unique case (state_q)
            RECV: begin
                if (in_fire) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = COL_ISSUE;
                        k_d     = '0;
                    end
                end
            end
            COL_ISSUE: begin
                if (c_fire) state_d = COL_WAIT;
            end
            COL_WAIT: begin
                if (r_fire) begin
                    k_d     = k_q + 3'd1;
                    state_d = (k_q == 3'd7) ? ROW_ISSUE : COL_ISSUE;
                end
            end
            ROW_ISSUE: begin
                if (c_fire) state_d = ROW_WAIT;
            end
            ROW_WAIT: begin
                if (r_fire) begin
                    k_d     = k_q + 3'd1;
                    state_d = ROW_ISSUE;
                    if (k_q == 3'd7) begin
                        state_d = SEND;
                        dx_d    = bus.dst_x;
                        dy_d    = bus.dst_y;
                    end
                end
            end
            SEND: begin
                if (o_fire) begin
                    k_d = k_q + 3'd1;
                    if (k_q == 3'd7) state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RECV;
            k_q     <= '0;
            cnt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_block_idct.sv
// Scoreboard bench for block_idct with a behavioural 1-D core
// (identity or element-reversing) and configurable core stalls.
module tb_block_idct;
    localparam int TW = 280;

    logic clk;
    logic rstn;

    block_idct_if #(
        .X_SIZE(4), .Y_SIZE(4), .PCK_NUM(16), .DATA_WIDTH(256)
    ) bus ();

    block_idct #(
        .X_SIZE(4), .Y_SIZE(4), .PCK_NUM(16), .DATA_WIDTH(256)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [TW-1:0] exp_q [$];

    int cyc = 0;
    int acc_cyc = 0;
    int out_total = 0;
    int ntx = 0;
    int tx_base = 0;
    int core_mode = 0;
    int c_stall = 0;
    int r_dly = 0;
    bit chk_tx = 0;
    bit tog = 0;

    bit c_fire_s, r_fire_s;
    logic [255:0] cd_s;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [TW-1:0] act,
                       input logic [TW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Element k = a + s*k, element 0 at the MSB end.
    function automatic logic [255:0] pl(input int a, input int s);
        logic [255:0] v = '0;
        for (int k = 0; k < 8; k++) v = (v << 32) | 256'(32'(a + s * k));
        return v;
    endfunction

    function automatic logic [255:0] rev(input logic [255:0] d);
        logic [255:0] t = d;
        logic [255:0] r = '0;
        for (int j = 0; j < 8; j++) begin
            r = (r << 32) | 256'(t[31:0]);
            t = t >> 32;
        end
        return r;
    endfunction

    // Behavioural core: one transaction at a time, optional stalls.
    initial begin
        bit pend = 0;
        int stall = 0;
        int dly = 0;
        int n;
        logic [255:0] res = '0;
        bus.c_ready = 0;
        bus.r_valid = 0;
        bus.r_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                bus.c_ready = 0;
                bus.r_valid = 0;
                pend  = 0;
                stall = c_stall;
            end else begin
                if (r_fire_s) begin
                    bus.r_valid = 0;
                    pend = 0;
                end
                if (c_fire_s) begin
                    bus.c_ready = 0;
                    pend  = 1;
                    res   = (core_mode == 1) ? rev(cd_s) : cd_s;
                    dly   = r_dly;
                    stall = c_stall;
                    n = ntx - tx_base;
                    if (chk_tx)
                        chk("core_tx", cd_s, (n < 8) ? pl(n, 8) : pl(8 * (n - 8), 1));
                    ntx++;
                end
                if (pend && !bus.r_valid) begin
                    if (dly == 0) begin
                        bus.r_valid = 1;
                        bus.r_data  = res;
                    end else begin
                        dly--;
                    end
                end
                if (!pend && !bus.c_valid) stall = c_stall;
                if (!pend && bus.c_valid) begin
                    if (stall == 0) bus.c_ready = 1;
                    else stall--;
                end
            end
        end
    end

    initial begin
        bit [3:0] rpat = 4'b1001;
        int ph = 0;
        bus.i_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (tog) begin
                bus.i_ready = rpat[ph];
                ph = (ph + 1) % 4;
            end else begin
                bus.i_ready = 1;
            end
        end
    end

    // Monitor: samples mid-cycle, pops the scoreboard on each output beat.
    initial begin
        bit c_stall_p = 0, o_stall_p = 0, busy = 0, seen_first = 0;
        int inb = 0, outb = 0;
        logic [255:0] c_prev = '0;
        logic [TW-1:0] o_prev = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                c_fire_s = 0; r_fire_s = 0;
                c_stall_p = 0; o_stall_p = 0;
                busy = 0; inb = 0; outb = 0;
            end else begin
                c_fire_s = bus.c_valid && bus.c_ready;
                r_fire_s = bus.r_valid && bus.r_ready;
                cd_s = bus.c_data;
                if (c_stall_p) begin
                    chk("c_hold_valid", TW'(bus.c_valid), 1);
                    chk("c_hold_data", TW'(bus.c_data), TW'(c_prev));
                end
                c_stall_p = bus.c_valid && !bus.c_ready;
                c_prev = bus.c_data;

                if (o_stall_p) begin
                    chk("o_hold_valid", TW'(bus.o_valid), 1);
                    chk("o_hold_data", bus.o_data, o_prev);
                end
                if (bus.o_valid && !seen_first) begin
                    seen_first = 1;
                    chk("latency", TW'(cyc - acc_cyc), 32);
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL o_extra: got %0h expected no beat", bus.o_data);
                    end else begin
                        chk("o_data", bus.o_data, exp_q.pop_front());
                    end
                    out_total++;
                    outb++;
                    if (outb == 8) begin busy = 0; outb = 0; end
                end
                o_stall_p = bus.o_valid && !bus.i_ready;
                o_prev = bus.o_data;

                if (busy && bus.i_valid)
                    chk("no_accept_busy", TW'(bus.o_ready), 0);
                if (bus.i_valid && bus.o_ready) begin
                    inb++;
                    if (inb == 8) begin busy = 1; inb = 0; end
                end
            end
        end
    end

    task automatic send_row(input int pck, input logic [255:0] p);
        bit ok = 0;
        bus.i_data  = {p, 16'(pck), 4'hA, 4'h5};
        bus.i_valid = 1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.o_ready;
            @(posedge clk);
            #1;
        end
        bus.i_valid = 0;
        acc_cyc = cyc;
        chk("in_accept", TW'(ok), 1);
    endtask

    task automatic run_block(input int base, input int pstart, input int pstep,
                             input int phi, input int mode, input int dx,
                             input int dy, input bit push, input bit hold);
        int pck, r;
        core_mode = mode;
        bus.dst_x = 4'(dx);
        bus.dst_y = 4'(dy);
        tx_base = ntx;
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({(mode == 0) ? pl(base + 8 * i, 1)
                                             : pl(base + 8 * (7 - i) + 7, -1),
                                 16'(phi + i), 4'(dy), 4'(dx)});
            end
        end
        for (int i = 0; i < 8; i++) begin
            pck = pstart + pstep * i;
            r = pck & 7;
            send_row(pck, pl(base + 8 * r, 1));
        end
        if (hold) begin
            bus.i_data  = {256'hDEAD, 16'd3, 8'h00};
            bus.i_valid = 1;
        end
    endtask

    task automatic wait_out(input int target);
        for (int t = 0; t < 3000 && out_total < target; t++) @(posedge clk);
        chk("out_count", TW'(out_total), TW'(target));
        chk("ntx", TW'(ntx - tx_base), 16);
    endtask

    initial begin
        bit ok = 0;
        rstn = 0;
        bus.i_valid = 0;
        bus.i_data  = '0;
        bus.dst_x   = '0;
        bus.dst_y   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_ready", TW'(bus.o_ready), 1);
        chk("rst_o_valid", TW'(bus.o_valid), 0);
        chk("rst_c_valid", TW'(bus.c_valid), 0);
        chk("rst_r_ready", TW'(bus.r_ready), 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_c_data", TW'(bus.c_data), 0);
        rstn = 1;
        @(posedge clk);
        #1;

        chk_tx = 1;
        run_block(0, 0, 1, 0, 0, 3, 5, 1, 0);
        wait_out(8);
        chk_tx = 0;

        run_block(0, 0, 1, 0, 1, 9, 2, 1, 0);
        wait_out(16);

        run_block(100, 15, -1, 8, 0, 1, 14, 1, 0);
        wait_out(24);

        tog = 1;
        run_block(200, 0, 1, 0, 0, 15, 0, 1, 1);
        wait_out(32);
        bus.i_valid = 0;
        tog = 0;
        @(posedge clk);
        #1;

        c_stall = 3;
        r_dly = 4;
        run_block(300, 0, 1, 0, 0, 6, 7, 1, 0);
        wait_out(40);

        run_block(400, 0, 1, 0, 0, 2, 2, 0, 0);
        for (int t = 0; t < 200 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = bus.r_ready;
        end
        chk("reach_col_wait", TW'(ok), 1);
        rstn = 0;
        c_stall = 0;
        r_dly = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_o_ready", TW'(bus.o_ready), 1);
        chk("mid_rst_c_valid", TW'(bus.c_valid), 0);
        chk("mid_rst_r_ready", TW'(bus.r_ready), 0);
        chk("mid_rst_o_valid", TW'(bus.o_valid), 0);
        @(posedge clk);
        #1;
        rstn = 1;
        @(posedge clk);
        #1;

        run_block(500, 0, 1, 0, 1, 12, 10, 1, 0);
        wait_out(48);
        repeat (20) @(posedge clk);
        chk("out_total_final", TW'(out_total), 48);
        chk("q_empty", TW'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
